// File: rtl/mfp_fifo_ctrl_if.sv
// mfp_fifo_ctrl_if: push/pop handshakes, status flags and RAM port bundle of the FIFO controller.
// Latency: none, plain wires.
// Backpressure: carried by full/empty; the controller rejects pushes while full and pops while empty.
interface mfp_fifo_ctrl_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  // user side
  logic                  push;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  pop_valid;
  logic                  clear_err;
  // status
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;
  // RAM side
  logic [ADDR_WIDTH-1:0] ram_write_addr;
  logic [DATA_WIDTH-1:0] ram_write_data;
  logic                  ram_write_enable;
  logic [ADDR_WIDTH-1:0] ram_read_addr;
  logic [DATA_WIDTH-1:0] ram_read_data;

  // environment view: the FIFO user plus the RAM
  modport master (
    output push, push_data, pop, clear_err, ram_read_data,
    input  pop_data, pop_valid, full, empty, almost_full, count, overflow, underflow,
    input  ram_write_addr, ram_write_data, ram_write_enable, ram_read_addr
  );

  // controller view
  modport slave (
    input  push, push_data, pop, clear_err, ram_read_data,
    output pop_data, pop_valid, full, empty, almost_full, count, overflow, underflow,
    output ram_write_addr, ram_write_data, ram_write_enable, ram_read_addr
  );
endinterface

// File: rtl/mfp_fifo_ctrl.sv
// mfp_fifo_ctrl: pointer/flag controller in front of a registered-read simple dual-port RAM.
// Latency: accepted push shows in count next cycle; pop_data valid one cycle after an accepted pop.
// Backpressure: push rejected while full, pop rejected while empty; rejections set sticky error flags.
module mfp_fifo_ctrl #(
  parameter int ADDR_WIDTH        = 6,
  parameter int DATA_WIDTH        = 32,
  parameter int ALMOST_FULL_LEVEL = (1 << ADDR_WIDTH) - 2
) (
  input logic            clk,
  input logic            resetn,
  mfp_fifo_ctrl_if.slave bus
);
  localparam int PTR_WIDTH = ADDR_WIDTH + 1;
  localparam logic [PTR_WIDTH-1:0] AF_LEVEL = PTR_WIDTH'(ALMOST_FULL_LEVEL);

  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  occupancy;
  logic                  full;
  logic                  empty;
  logic                  push_accept;
  logic                  pop_accept;
  logic                  pop_valid;
  logic                  overflow;
  logic                  underflow;
  logic [DATA_WIDTH-1:0] head_data;

  // Status from pre-edge pointers; the extra MSB distinguishes full from empty.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                     (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign occupancy = wr_ptr - rd_ptr;

  // Writes are held off while reset is asserted so a stray push cannot touch the RAM.
  assign push_accept = bus.push & ~full & resetn;
  assign pop_accept  = bus.pop & ~empty;

  // RAM write port follows the tail; read port always addresses the head.
  assign bus.ram_write_enable = push_accept;
  assign bus.ram_write_addr   = wr_ptr[ADDR_WIDTH-1:0];
  assign bus.ram_write_data   = bus.push_data;
  assign bus.ram_read_addr    = rd_ptr[ADDR_WIDTH-1:0];

  // The RAM registers the head at the pop edge, so its output is the popped word.
  assign head_data    = bus.ram_read_data;
  assign bus.pop_data = head_data;

  assign bus.pop_valid   = pop_valid;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.count       = occupancy;
  assign bus.almost_full = (occupancy >= AF_LEVEL);
  assign bus.overflow    = overflow;
  assign bus.underflow   = underflow;

  // Pointer advance; both may move in the same cycle, leaving occupancy unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_accept) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (pop_accept)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
    end
  end

  // pop_valid marks the cycle the RAM's registered output holds the popped word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pop_valid <= 1'b0;
    else         pop_valid <= pop_accept;
  end

  // Sticky error flags; a new error in the same cycle wins over clear_err.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (bus.push && full)      overflow <= 1'b1;
      else if (bus.clear_err)    overflow <= 1'b0;
      if (bus.pop && empty)      underflow <= 1'b1;
      else if (bus.clear_err)    underflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mfp_fifo_ctrl.sv
// tb_mfp_fifo_ctrl: self-checking bench for mfp_fifo_ctrl with a small registered-read RAM model.
// Latency: checks pop_data one cycle after each accepted pop through a scoreboard queue.
// Backpressure: exercises full/empty rejection, error flags, wrap and async reset.
module tb_mfp_fifo_ctrl;
  localparam int AW    = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  mfp_fifo_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  mfp_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  // RAM model: simple dual port, registered read
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;
  always @(posedge clk) begin
    if (bus.ram_write_enable) mem[bus.ram_write_addr] <= bus.ram_write_data;
    rd_q <= mem[bus.ram_read_addr];
  end
  assign bus.ram_read_data = rd_q;

  // scoreboard and reference state
  logic [DW-1:0] exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            m_count;
  logic [AW:0]   m_wr, m_rd;
  logic          m_ovf, m_unf, m_pv;

  // compare each delivered word with the oldest expected one
  always @(negedge clk) begin
    if (resetn === 1'b1 && bus.pop_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_extra: pop_valid with nothing expected, got %0h", bus.pop_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (bus.pop_data !== e) begin
          n_err++;
          $display("FAIL pop_data: got %0h expected %0h", bus.pop_data, e);
        end
      end
    end
  end

  task automatic model_reset();
    m_count = 0; m_wr = '0; m_rd = '0; m_ovf = 1'b0; m_unf = 1'b0; m_pv = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_in(input logic ps, input logic [DW-1:0] pd, input logic pp, input logic ce);
    bus.push = ps; bus.push_data = pd; bus.pop = pp; bus.clear_err = ce;
    #1;
  endtask

  // advance one clock, updating the reference model from the pre-edge inputs
  task automatic tick();
    logic ap, aq;
    ap = bus.push && (m_count < DEPTH);
    aq = bus.pop && (m_count > 0);
    if (resetn) begin
      if (bus.push && m_count == DEPTH) m_ovf = 1'b1; else if (bus.clear_err) m_ovf = 1'b0;
      if (bus.pop && m_count == 0)      m_unf = 1'b1; else if (bus.clear_err) m_unf = 1'b0;
      if (ap) begin exp_q.push_back(bus.push_data); m_wr = m_wr + 1'b1; end
      if (aq) m_rd = m_rd + 1'b1;
      m_count = m_count + (ap ? 1 : 0) - (aq ? 1 : 0);
      m_pv = aq;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    model_reset();
    set_in(1'b1, 32'hDEAD, 1'b0, 1'b0);
    n_cmp++; if (bus.ram_write_enable !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b expected 0", bus.ram_write_enable); end
    tick(); tick();
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
    n_cmp++; if (bus.full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b expected 0", bus.full); end
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    n_cmp++; if (bus.pop_valid !== 1'b0) begin n_err++; $display("FAIL reset_pop_valid: got %b expected 0", bus.pop_valid); end
    n_cmp++; if (bus.almost_full !== 1'b0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_err++; $display("FAIL reset_flags: got af=%b ovf=%b unf=%b expected 0", bus.almost_full, bus.overflow, bus.underflow);
    end
    set_in(1'b0, '0, 1'b0, 1'b0);
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      int ec;
      set_in(1'b1, 32'hA0 + i, 1'b0, 1'b0);
      n_cmp++; if (bus.ram_write_enable !== (i < 4)) begin n_err++; $display("FAIL fill_we[%0d]: got %b expected %b", i, bus.ram_write_enable, (i < 4)); end
      if (i < 4) begin
        n_cmp++; if (bus.ram_write_addr !== AW'(i)) begin n_err++; $display("FAIL fill_waddr[%0d]: got %0d expected %0d", i, bus.ram_write_addr, i); end
      end
      tick();
      ec = (i < 4) ? i + 1 : 4;
      n_cmp++; if (bus.count !== 3'(ec)) begin n_err++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, bus.count, ec); end
      n_cmp++; if (bus.almost_full !== (ec >= 2)) begin n_err++; $display("FAIL fill_af[%0d]: got %b expected %b", i, bus.almost_full, (ec >= 2)); end
      n_cmp++; if (bus.full !== (ec == 4)) begin n_err++; $display("FAIL fill_full[%0d]: got %b expected %b", i, bus.full, (ec == 4)); end
      n_cmp++; if (bus.overflow !== (i == 4)) begin n_err++; $display("FAIL fill_ovf[%0d]: got %b expected %b", i, bus.overflow, (i == 4)); end
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, '0, 1'b1, 1'b0);
      tick();
      n_cmp++; if (bus.pop_valid !== (i < 4)) begin n_err++; $display("FAIL drain_pv[%0d]: got %b expected %b", i, bus.pop_valid, (i < 4)); end
      n_cmp++; if (bus.count !== 3'((i < 4) ? 3 - i : 0)) begin n_err++; $display("FAIL drain_count[%0d]: got %0d", i, bus.count); end
    end
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b expected 1", bus.empty); end
    n_cmp++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL drain_unf: got %b expected 1", bus.underflow); end
    set_in(1'b0, '0, 1'b0, 1'b1);
    tick();
    n_cmp++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_err++; $display("FAIL clear_err: got ovf=%b unf=%b expected 0 0", bus.overflow, bus.underflow);
    end
    set_in(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_empty_push_pop();
    set_in(1'b1, 32'h300, 1'b1, 1'b0);
    n_cmp++; if (bus.ram_write_enable !== 1'b1) begin n_err++; $display("FAIL epp_we: got %b expected 1", bus.ram_write_enable); end
    tick();
    n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL epp_count: got %0d expected 1", bus.count); end
    n_cmp++; if (bus.pop_valid !== 1'b0) begin n_err++; $display("FAIL epp_pv: got %b expected 0", bus.pop_valid); end
    n_cmp++; if (bus.underflow !== 1'b1) begin n_err++; $display("FAIL epp_unf: got %b expected 1", bus.underflow); end
    set_in(1'b0, '0, 1'b1, 1'b1);
    tick();
    n_cmp++; if (bus.pop_valid !== 1'b1 || bus.underflow !== 1'b0) begin
      n_err++; $display("FAIL epp_drain: got pv=%b unf=%b expected 1 0", bus.pop_valid, bus.underflow);
    end
    set_in(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    set_in(1'b1, 32'hFF, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 32'h100 + i, 1'b1, 1'b0);
      n_cmp++; if (bus.ram_write_addr !== m_wr[AW-1:0] || bus.ram_read_addr !== m_rd[AW-1:0]) begin
        n_err++; $display("FAIL wrap_addr[%0d]: got w=%0d r=%0d expected w=%0d r=%0d", i, bus.ram_write_addr, bus.ram_read_addr, m_wr[AW-1:0], m_rd[AW-1:0]);
      end
      tick();
      n_cmp++; if (bus.count !== 3'd1 || bus.pop_valid !== 1'b1) begin
        n_err++; $display("FAIL wrap_step[%0d]: got count=%0d pv=%b expected 1 1", i, bus.count, bus.pop_valid);
      end
    end
    set_in(1'b0, '0, 1'b1, 1'b0);
    tick();
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got %b expected 1", bus.empty); end
    set_in(1'b0, '0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h200 + i, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 32'h2FF, 1'b1, 1'b0);
    n_cmp++; if (bus.ram_write_enable !== 1'b0) begin n_err++; $display("FAIL fpp_we: got %b expected 0", bus.ram_write_enable); end
    tick();
    n_cmp++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL fpp_count: got %0d expected 3", bus.count); end
    n_cmp++; if (bus.overflow !== 1'b1 || bus.pop_valid !== 1'b1) begin
      n_err++; $display("FAIL fpp_flags: got ovf=%b pv=%b expected 1 1", bus.overflow, bus.pop_valid);
    end
    set_in(1'b1, 32'h204, 1'b0, 1'b1);
    tick();
    n_cmp++; if (bus.overflow !== 1'b0 || bus.full !== 1'b1) begin
      n_err++; $display("FAIL fpp_clear: got ovf=%b full=%b expected 0 1", bus.overflow, bus.full);
    end
    // error and clear in the same cycle: the error sticks
    set_in(1'b1, 32'h2EE, 1'b0, 1'b1);
    tick();
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL fpp_set_prio: got %b expected 1", bus.overflow); end
    set_in(1'b0, '0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, '0, 1'b0, 1'b1);
    tick();
    n_cmp++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      n_err++; $display("FAIL fpp_noerr_clear: got ovf=%b unf=%b expected 0 0", bus.overflow, bus.underflow);
    end
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, '0, 1'b1, 1'b0);
      tick();
    end
    set_in(1'b0, '0, 1'b0, 1'b0);
    tick();
    n_cmp++; if (bus.empty !== 1'b1) begin n_err++; $display("FAIL fpp_drained: got %b expected 1", bus.empty); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h400 + i, 1'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 32'h403, 1'b1, 1'b0);
    tick();
    n_cmp++; if (bus.count !== 3'd3 || bus.pop_valid !== 1'b1) begin
      n_err++; $display("FAIL ar_pre: got count=%0d pv=%b expected 3 1", bus.count, bus.pop_valid);
    end
    set_in(1'b0, '0, 1'b0, 1'b0);
    #1 resetn = 1'b0;
    #1;
    n_cmp++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin
      n_err++; $display("FAIL ar_immediate: got count=%0d empty=%b expected 0 1", bus.count, bus.empty);
    end
    n_cmp++; if (bus.pop_valid !== 1'b0) begin n_err++; $display("FAIL ar_pv: got %b expected 0", bus.pop_valid); end
    model_reset();
    resetn = 1'b1;
    set_in(1'b1, 32'h55, 1'b0, 1'b0);
    tick();
    set_in(1'b0, '0, 1'b1, 1'b0);
    tick();
    n_cmp++; if (bus.pop_valid !== 1'b1 || bus.empty !== 1'b1) begin
      n_err++; $display("FAIL ar_after: got pv=%b empty=%b expected 1 1", bus.pop_valid, bus.empty);
    end
    set_in(1'b0, '0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_empty_push_pop();
    test_wrap();
    test_full_push_pop();
    test_async_reset();
    tick();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_left: got %0d words undelivered expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
